// File: rtl/seq_restoring_divider.sv
// Sequential 4-bit unsigned restoring divider.
// Three-state FSM (IDLE, DIVIDE, DONE). DIVIDE runs four iterations, MSB first, over a
// 5-bit partial remainder. Each trial subtraction adds the one's complement of the
// divisor with carry-in 1. Divide-by-zero early exit is optional: define DIVZERO_FLAG_EN
// to enable it and to add the div_by_zero port. With the macro undefined, a zero divisor
// takes the normal path and yields quotient 4'hF, remainder = dividend.

module seq_restoring_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done
`ifdef DIVZERO_FLAG_EN
    ,
    output logic       div_by_zero
`endif
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDivide = 2'd1,
        StDone   = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] prem_q, prem_d;   // partial remainder
    logic [3:0] dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
    logic [3:0] dvs_q, dvs_d;     // captured divisor
    logic [1:0] cnt_q, cnt_d;     // iteration counter
    logic [3:0] quot_q, quot_d;
    logic [3:0] rem_q, rem_d;

    logic [4:0] shifted;
    logic [5:0] trial;
    logic       qbit;
    logic [4:0] prem_next;
    logic       accept;

`ifdef DIVZERO_FLAG_EN
    logic dz_q, dz_d;
    // Zero divisor accepted on the previous edge; results are written on the next edge
    // while the FSM stays in IDLE, so busy never rises for this case.
    logic dz_pend_q, dz_pend_d;
`endif

    // One restoring iteration: shift in next dividend bit, trial-subtract, restore on borrow.
    always_comb begin
        shifted   = {prem_q[3:0], dvd_q[3]};
        trial     = {1'b0, shifted} + {1'b0, 1'b1, ~dvs_q} + 6'd1;
        qbit      = trial[5];
        prem_next = qbit ? trial[4:0] : shifted;
    end

    // start is honoured only outside DIVIDE (and not while a zero-divisor result is pending).
    always_comb begin
`ifdef DIVZERO_FLAG_EN
        accept = start && (state_q != StDivide) && !dz_pend_q;
`else
        accept = start && (state_q != StDivide);
`endif
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef DIVZERO_FLAG_EN
        dz_d      = dz_q;
        dz_pend_d = dz_pend_q;
`endif

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
`ifdef DIVZERO_FLAG_EN
                if (dz_pend_q) begin
                    state_d   = StDone;
                    quot_d    = 4'hF;
                    rem_d     = dvd_q;
                    dz_pend_d = 1'b0;
                end else
`endif
                if (accept) begin
                    dvd_d  = dividend;
                    dvs_d  = divisor;
                    prem_d = 5'd0;
                    cnt_d  = 2'd0;
`ifdef DIVZERO_FLAG_EN
                    dz_d = (divisor == 4'd0);
                    if (divisor == 4'd0) begin
                        dz_pend_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        state_d = StDivide;
                    end
`else
                    state_d = StDivide;
`endif
                end
            end

            StDivide: begin
                prem_d = prem_next;
                dvd_d  = {dvd_q[2:0], qbit};
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    // Results are published only here, so partial values never leak out.
                    state_d = StDone;
                    quot_d  = {dvd_q[2:0], qbit};
                    rem_d   = prem_next[3:0];
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            prem_q  <= 5'd0;
            dvd_q   <= 4'd0;
            dvs_q   <= 4'd0;
            cnt_q   <= 2'd0;
            quot_q  <= 4'd0;
            rem_q   <= 4'd0;
`ifdef DIVZERO_FLAG_EN
            dz_q      <= 1'b0;
            dz_pend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            prem_q  <= prem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
`ifdef DIVZERO_FLAG_EN
            dz_q      <= dz_d;
            dz_pend_q <= dz_pend_d;
`endif
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        busy      = (state_q == StDivide);
        done      = (state_q == StDone);
        quotient  = quot_q;
        remainder = rem_q;
`ifdef DIVZERO_FLAG_EN
        div_by_zero = dz_q;
`endif
    end

endmodule
